// File: rtl/simon_audio_pkg.sv
// Shared definitions for the Simon audio path.
//   - widths of the note code, duration and oscillator half-period words
//   - note codes and their oscillator half-period constants
//   - tone sequencer FSM state encoding
//   - packed request record stored in the request queue
//   - note_half_wav()/note_audible() lookup helpers
package simon_audio_pkg;

  localparam int HALF_WAV_W = 20;
  localparam int DUR_W      = 12;
  localparam int NOTE_W     = 3;

  // Note codes; anything above CODE_ERROR is a rest (silence).
  localparam logic [NOTE_W-1:0] CODE_GREEN  = 3'd0;
  localparam logic [NOTE_W-1:0] CODE_RED    = 3'd1;
  localparam logic [NOTE_W-1:0] CODE_YELLOW = 3'd2;
  localparam logic [NOTE_W-1:0] CODE_BLUE   = 3'd3;
  localparam logic [NOTE_W-1:0] CODE_ERROR  = 3'd4;

  // half_wav = round(50e6 / (2 * f)) - 1
  localparam logic [HALF_WAV_W-1:0] NOTE_GREEN  = 20'd60240;   // 415 Hz
  localparam logic [HALF_WAV_W-1:0] NOTE_RED    = 20'd80644;   // 310 Hz
  localparam logic [HALF_WAV_W-1:0] NOTE_YELLOW = 20'd99205;   // 252 Hz
  localparam logic [HALF_WAV_W-1:0] NOTE_BLUE   = 20'd119616;  // 209 Hz
  localparam logic [HALF_WAV_W-1:0] NOTE_ERROR  = 20'd595237;  //  42 Hz

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur_ms;
  } tone_req_t;

  function automatic logic [HALF_WAV_W-1:0] note_half_wav(input logic [NOTE_W-1:0] note);
    case (note)
      CODE_GREEN:  return NOTE_GREEN;
      CODE_RED:    return NOTE_RED;
      CODE_YELLOW: return NOTE_YELLOW;
      CODE_BLUE:   return NOTE_BLUE;
      CODE_ERROR:  return NOTE_ERROR;
      default:     return '0;
    endcase
  endfunction

  function automatic logic note_audible(input logic [NOTE_W-1:0] note);
    return note <= CODE_ERROR;
  endfunction

endpackage

// File: rtl/tone_req_fifo.sv
// Synchronous request queue for the tone sequencer.
// Ports:
//   CLOCK_50   in   clock
//   reset      in   synchronous, active-high; empties the queue
//   push       in   write wdata (ignored when full, even if popping)
//   wdata      in   WIDTH-bit entry
//   pop        in   drop head entry (ignored when empty)
//   rdata      out  head entry (valid when !empty)
//   full/empty out  occupancy flags
module tone_req_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves it unassigned would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and a reset-free array maps onto plain RAM/SRL cells.
  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tone_sequencer.sv
// Tone sequencer: queues Simon note requests {note, duration_ms} and plays
// them back-to-back on the square-wave oscillator.
// Ports:
//   CLOCK_50    in   system clock (50 MHz)
//   reset       in   synchronous, active-high
//   req_valid   in   request present;   req_ready out: queue can accept
//   req_note    in   note code (0..4 audible, 5..7 rest)
//   req_dur_ms  in   note length in ms (0 plays as 1 ms)
//   half_wav    out  oscillator half-period word, changes only on a pop
//   osc_reset   out  high = oscillator parked
//   tone_on     out  high while an audible note plays
//   busy        out  queue non-empty or a note/gap in progress
//   note_done   out  one-cycle pulse on the last PLAY cycle of each note
// Build option: define TONE_GAP_EN to insert a GAP_MS silent gap after
// every note; without it PLAY returns straight to IDLE.
module tone_sequencer
  import simon_audio_pkg::*;
#(
  parameter int MS_DIV     = 50_000,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_MS     = 50
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NOTE_W-1:0]     req_note,
  input  logic [DUR_W-1:0]      req_dur_ms,
  output logic [HALF_WAV_W-1:0] half_wav,
  output logic                  osc_reset,
  output logic                  tone_on,
  output logic                  busy,
  output logic                  note_done
);

  localparam int               PRE_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = 1;
  localparam logic [DUR_W-1:0] DUR_ONE  = 1;
  localparam logic [DUR_W-1:0] GAP_LOAD = (GAP_MS < 1) ? DUR_ONE : DUR_W'(GAP_MS);

  state_t                  state_q, state_d;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [DUR_W-1:0]        dur_q, dur_d;
  logic [HALF_WAV_W-1:0]   half_wav_q, half_wav_d;
  logic                    audible_q, audible_d;

  tone_req_t req_in, fifo_rdata;
  logic      fifo_full, fifo_empty, pop;
  logic      ms_wrap, count_done;

  assign req_in    = '{note: req_note, dur_ms: req_dur_ms};
  assign req_ready = !reset && !fifo_full;

  tone_req_fifo #(
    .WIDTH ($bits(tone_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .push     (req_valid && req_ready),
    .wdata    (req_in),
    .pop      (pop),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // One shared ms prescaler + ms counter times both PLAY and GAP.
  assign ms_wrap    = (pre_q == PRE_LAST);
  assign count_done = ms_wrap && (dur_q == DUR_ONE);

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pre_q      <= '0;
      dur_q      <= '0;
      half_wav_q <= '0;
      audible_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      dur_q      <= dur_d;
      half_wav_q <= half_wav_d;
      audible_q  <= audible_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    dur_d      = dur_q;
    half_wav_d = half_wav_q;
    audible_d  = audible_q;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_d    = ST_PLAY;
          half_wav_d = note_half_wav(fifo_rdata.note);
          audible_d  = note_audible(fifo_rdata.note);
          dur_d      = (fifo_rdata.dur_ms == '0) ? DUR_ONE : fifo_rdata.dur_ms;
          pre_d      = '0;
        end
      end

      ST_PLAY: begin
        if (count_done) begin
`ifdef TONE_GAP_EN
          state_d = ST_GAP;
`else
          state_d = ST_IDLE;
`endif
          // Reload for the gap; the counter value is ignored in IDLE.
          pre_d = '0;
          dur_d = GAP_LOAD;
        end else if (ms_wrap) begin
          pre_d = '0;
          dur_d = dur_q - DUR_ONE;
        end else begin
          pre_d = pre_q + PRE_ONE;
        end
      end

`ifdef TONE_GAP_EN
      ST_GAP: begin
        if (count_done) begin
          state_d = ST_IDLE;
          pre_d   = '0;
        end else if (ms_wrap) begin
          pre_d = '0;
          dur_d = dur_q - DUR_ONE;
        end else begin
          pre_d = pre_q + PRE_ONE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    osc_reset = 1'b1;
    tone_on   = 1'b0;
    note_done = 1'b0;
    if (state_q == ST_PLAY) begin
      // Rests keep the oscillator parked but still time out and report done.
      osc_reset = !audible_q;
      tone_on   = audible_q;
      note_done = count_done;
    end
  end

  assign busy     = !fifo_empty || (state_q != ST_IDLE);
  assign half_wav = half_wav_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer (MS_DIV=10, FIFO_DEPTH=4, GAP_MS=2).
// Accepted requests push their expected result to a scoreboard queue; a
// negedge monitor pops and compares on every note_done pulse.
module tb_tone_sequencer;

  localparam int MS_DIV     = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_MS     = 2;
`ifdef TONE_GAP_EN
  localparam int GAP_CYC = GAP_MS * MS_DIV;
`else
  localparam int GAP_CYC = 0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_note;
  logic [11:0] req_dur_ms;
  logic [19:0] half_wav;
  logic        osc_reset;
  logic        tone_on;
  logic        busy;
  logic        note_done;

  tone_sequencer #(
    .MS_DIV     (MS_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_MS     (GAP_MS)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_note   (req_note),
    .req_dur_ms (req_dur_ms),
    .half_wav   (half_wav),
    .osc_reset  (osc_reset),
    .tone_on    (tone_on),
    .busy       (busy),
    .note_done  (note_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [19:0] half;
    bit          audible;
    int          len;
  } exp_t;

  typedef struct {
    logic [2:0]  note;
    logic [11:0] dur;
    logic [19:0] half;
    bit          audible;
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   run_len = 0;
  int   done_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Present one request, hold it until accepted, record its expectation.
  task automatic send(input logic [2:0] note, input logic [11:0] dur,
                      input logic [19:0] half, input bit aud, output int stall);
    exp_t e;
    stall      = 0;
    req_note   = note;
    req_dur_ms = dur;
    req_valid  = 1'b1;
    while (!req_ready && stall < 1000) begin
      step();
      stall++;
    end
    if (!req_ready) check("accept_timeout", 0, 1);
    e.half    = half;
    e.audible = aud;
    e.len     = ((dur == 12'd0) ? 1 : int'(dur)) * MS_DIV;
    sb.push_back(e);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(output int len);
    len = 0;
    while (busy && len < 5000) begin
      step();
      len++;
    end
    if (busy) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_tone(input bit level);
    int n = 0;
    while (tone_on != level && n < 2000) begin
      step();
      n++;
    end
    if (tone_on != level) check("tone_wait_timeout", int'(tone_on), int'(level));
  endtask

  // Scoreboard monitor: compare each finished note against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (tone_on) run_len++;
      else         run_len = 0;
      if (note_done) begin
        done_seen++;
        if (sb.size() == 0) begin
          check("unexpected_note_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("note_half_wav",  int'(half_wav),  int'(e.half));
          check("note_tone_on",   int'(tone_on),   int'(e.audible));
          check("note_osc_reset", int'(osc_reset), int'(!e.audible));
          check("note_length",    run_len,         e.audible ? e.len : 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   stall, len, d0, off;

    vecs[0] = '{3'd0, 12'd3, 20'd60240,  1'b1};
    vecs[1] = '{3'd6, 12'd2, 20'd0,      1'b0};
    vecs[2] = '{3'd3, 12'd0, 20'd119616, 1'b1};
    vecs[3] = '{3'd1, 12'd2, 20'd80644,  1'b1};
    vecs[4] = '{3'd4, 12'd1, 20'd595237, 1'b1};
    vecs[5] = '{3'd7, 12'd1, 20'd0,      1'b0};
    vecs[6] = '{3'd2, 12'd2, 20'd99205,  1'b1};
    vecs[7] = '{3'd5, 12'd1, 20'd0,      1'b0};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_note   = '0;
    req_dur_ms = '0;
    repeat (3) step();

    // Reset state
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_half_wav",  int'(half_wav),  0);
    check("rst_osc_reset", int'(osc_reset), 1);
    check("rst_tone_on",   int'(tone_on),   0);
    check("rst_busy",      int'(busy),      0);
    check("rst_note_done", int'(note_done), 0);
    reset = 1'b0;
    step();
    check("post_rst_req_ready", int'(req_ready), 1);

    // Latency: accepted at T, IDLE at T+1, first PLAY cycle at T+2.
    d0 = done_seen;
    send(3'd0, 12'd3, 20'd60240, 1'b1, stall);
    check("lat_t1_tone_on", int'(tone_on), 0);
    check("lat_t1_busy",    int'(busy),    1);
    step();
    check("lat_t2_tone_on",   int'(tone_on),   1);
    check("lat_t2_osc_reset", int'(osc_reset), 0);
    check("lat_t2_half_wav",  int'(half_wav),  60240);
    wait_idle(len);
    check("lat_done_pulses", done_seen - d0, 1);
    check("lat_end_osc_reset", int'(osc_reset), 1);

    // Table: one note at a time into an idle block.
    for (int i = 0; i < 8; i++) begin
      d0 = done_seen;
      send(vecs[i].note, vecs[i].dur, vecs[i].half, vecs[i].audible, stall);
      wait_idle(len);
      check("vec_busy_len", len,
            1 + ((vecs[i].dur == 12'd0) ? 1 : int'(vecs[i].dur)) * MS_DIV + GAP_CYC);
      check("vec_done_pulses", done_seen - d0, 1);
      check("vec_idle_osc_reset", int'(osc_reset), 1);
      check("vec_idle_tone_on",   int'(tone_on),   0);
      check("vec_hold_half_wav",  int'(half_wav),  int'(vecs[i].half));
      check("vec_sb_empty", sb.size(), 0);
    end

    // Fill the queue behind a 2 ms note: the 5th request stalls until the
    // first queued note pops (20 play cycles + 1 idle - 3 push cycles).
    send(3'd0, 12'd2, 20'd60240,  1'b1, stall);
    send(3'd1, 12'd1, 20'd80644,  1'b1, stall);
    send(3'd2, 12'd1, 20'd99205,  1'b1, stall);
    send(3'd3, 12'd1, 20'd119616, 1'b1, stall);
    send(3'd4, 12'd1, 20'd595237, 1'b1, stall);
    check("fill_no_stall_4th", stall, 0);
    check("fill_full_ready", int'(req_ready), 0);
    send(3'd0, 12'd1, 20'd60240,  1'b1, stall);
    check("fill_stall_5th", stall, 18 + GAP_CYC);
    wait_idle(len);
    check("fill_sb_empty", sb.size(), 0);

    // Back-to-back separation between two identical notes.
    send(3'd0, 12'd1, 20'd60240, 1'b1, stall);
    send(3'd0, 12'd1, 20'd60240, 1'b1, stall);
    wait_tone(1'b1);
    wait_tone(1'b0);
    off = 0;
    while (!tone_on && off < 1000) begin
      step();
      off++;
    end
    check("b2b_silence", off, 1 + GAP_CYC);
    wait_idle(len);
    check("b2b_sb_empty", sb.size(), 0);

    // Reset mid-PLAY with two requests queued.
    d0 = done_seen;
    send(3'd2, 12'd5, 20'd99205,  1'b1, stall);
    send(3'd1, 12'd1, 20'd80644,  1'b1, stall);
    send(3'd3, 12'd1, 20'd119616, 1'b1, stall);
    repeat (15) step();
    check("mid_tone_on", int'(tone_on), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_req_ready", int'(req_ready), 0);
    step();
    check("mid_rst_osc_reset", int'(osc_reset), 1);
    check("mid_rst_tone_on",   int'(tone_on),   0);
    check("mid_rst_busy",      int'(busy),      0);
    check("mid_rst_half_wav",  int'(half_wav),  0);
    sb.delete();
    reset = 1'b0;
    len = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (busy) len++;
    end
    check("mid_post_busy_cycles", len, 0);
    check("mid_no_note_done", done_seen - d0, 0);
    d0 = done_seen;
    send(3'd3, 12'd1, 20'd119616, 1'b1, stall);
    wait_idle(len);
    check("mid_after_busy_len", len, 1 + MS_DIV + GAP_CYC);
    check("mid_after_done", done_seen - d0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
